mem_arbiter: RTL and testbench

- Shares the CPU's synchronous memory (one read port with 1-cycle latency, one write port) between the CPU and one external requester (debug/DMA host).
- The CPU always owns the read port unless the arbiter steals a cycle. It steals by asserting cpu_hold_o, which drives the CPU clock-enable (hold = freeze all CPU state).
- The arbiter replays the CPU's pending read data after a steal, so a held CPU never sees foreign data.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths and grant classes for the CPU/external memory arbiter.
// CPU, memory and arbiter all take their default widths from here.
package mem_arbiter_pkg;

  localparam int AWIDTH_DEF    = 16;
  localparam int DWIDTH_DEF    = 16;
  localparam int STEAL_GAP_DEF = 2;

  // Who owns the memory ports in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE     = 2'd0,  // CPU owns both ports
    GRANT_FREE_WR  = 2'd1,  // external write on the idle write port, CPU keeps running
    GRANT_STEAL_RD = 2'd2,  // CPU frozen, read port carries the external address
    GRANT_STEAL_WR = 2'd3   // CPU frozen, write port carries the external write
  } grant_e;

  // Width of the steal-gap counter. It never drops below one bit, so
  // STEAL_GAP=0 still yields a legal (constantly zero) register.
  function automatic int gap_width(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares a 1-cycle-latency synchronous memory between the CPU and one external
// requester; steals cycles by freezing the CPU and replays its pending read data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int STEAL_GAP = STEAL_GAP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] cpu_raddr_i,
  input  logic [AWIDTH-1:0] cpu_waddr_i,
  input  logic [DWIDTH-1:0] cpu_wdata_i,
  input  logic              cpu_wr_i,
  output logic [DWIDTH-1:0] cpu_rdata_o,
  output logic              cpu_hold_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [AWIDTH-1:0] ext_addr_i,
  input  logic [DWIDTH-1:0] ext_wdata_i,
  output logic              ext_ack_o,
  output logic              ext_rvalid_o,
  output logic [DWIDTH-1:0] ext_rdata_o,
  output logic [AWIDTH-1:0] mem_raddr_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic [AWIDTH-1:0] mem_waddr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_wr_o
);

  localparam int            GW       = gap_width(STEAL_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(STEAL_GAP);

  logic [GW-1:0]     gap_cnt;
  logic              prev_hold;
  logic [DWIDTH-1:0] replay;
  logic              ext_rvalid;

  logic   eligible;
  logic   gap_open;
  logic   steal;
  grant_e grant;

  // External handshake: ext_req_i is held with stable fields until ext_ack_o
  // pulses for one cycle; read data follows with ext_rvalid_o one cycle later.
  always_comb begin
    eligible = ext_req_i & ~reset;
    gap_open = (gap_cnt == '0);
    grant    = GRANT_NONE;
    if (eligible) begin
      if (ext_we_i && !cpu_wr_i) begin
        grant = GRANT_FREE_WR;
      end else if (gap_open) begin
        grant = ext_we_i ? GRANT_STEAL_WR : GRANT_STEAL_RD;
      end
    end
  end

  assign steal      = (grant == GRANT_STEAL_RD) || (grant == GRANT_STEAL_WR);
  assign cpu_hold_o = steal;
  assign ext_ack_o  = (grant != GRANT_NONE);

  // A stolen cycle drops the CPU write; the frozen CPU presents it again.
  always_comb begin
    mem_raddr_o = cpu_raddr_i;
    mem_waddr_o = cpu_waddr_i;
    mem_wdata_o = cpu_wdata_i;
    mem_wr_o    = cpu_wr_i & ~reset;
    case (grant)
      GRANT_FREE_WR, GRANT_STEAL_WR: begin
        mem_waddr_o = ext_addr_i;
        mem_wdata_o = ext_wdata_i;
        mem_wr_o    = 1'b1;
      end
      GRANT_STEAL_RD: begin
        mem_raddr_o = ext_addr_i;
        mem_wr_o    = 1'b0;
      end
      default: ;
    endcase
  end

  // After a run of holds the CPU must see the data for the address it issued
  // before the first hold, which was captured during that first held cycle.
  assign cpu_rdata_o  = prev_hold ? replay : mem_rdata_i;
  assign ext_rdata_o  = mem_rdata_i;
  assign ext_rvalid_o = ext_rvalid & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt    <= '0;
      prev_hold  <= 1'b0;
      replay     <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      if (steal) begin
        gap_cnt <= GAP_LOAD;
      end else if (!gap_open) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      prev_hold  <= steal;
      replay     <= cpu_rdata_o;
      ext_rvalid <= (grant == GRANT_STEAL_RD);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: two lanes (STEAL_GAP=2 and 0),
// each with its own memory, CPU/external drivers and a cycle-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   phase;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar l = 0; l < 2; l++) begin : lane
    localparam int GAP = (l == 0) ? 2 : 0;

    logic [15:0] cpu_raddr, cpu_waddr, cpu_wdata, cpu_rdata;
    logic        cpu_wr, cpu_hold;
    logic        ext_req, ext_we, ext_ack, ext_rvalid;
    logic [15:0] ext_addr, ext_wdata, ext_rdata;
    logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_wr;
    logic [15:0] mem [256];

    // Reference model state
    logic [15:0] model_mem [256];
    logic [15:0] cpu_q [$];
    logic [15:0] ext_q [$];
    int   cyc        = 0;
    int   last_steal = -100;
    int   wait_cnt   = 0;
    logic rv_due     = 1'b0;
    logic held_q     = 1'b0;
    logic acked_q    = 1'b0;

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .STEAL_GAP(GAP)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_raddr_i  (cpu_raddr),
      .cpu_waddr_i  (cpu_waddr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_wr_i     (cpu_wr),
      .cpu_rdata_o  (cpu_rdata),
      .cpu_hold_o   (cpu_hold),
      .ext_req_i    (ext_req),
      .ext_we_i     (ext_we),
      .ext_addr_i   (ext_addr),
      .ext_wdata_i  (ext_wdata),
      .ext_ack_o    (ext_ack),
      .ext_rvalid_o (ext_rvalid),
      .ext_rdata_o  (ext_rdata),
      .mem_raddr_o  (mem_raddr),
      .mem_rdata_i  (mem_rdata),
      .mem_waddr_o  (mem_waddr),
      .mem_wdata_o  (mem_wdata),
      .mem_wr_o     (mem_wr)
    );

    // Synchronous memory: read-before-write, one cycle of read latency.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int a = 0; a < 256; a++) mem[a] <= 16'h1000 + 16'(a);
      end else if (mem_wr) begin
        mem[mem_waddr[7:0]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_raddr[7:0]];
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s lane=%0d gap=%0d cyc=%0d got=%h exp=%h", name, l, GAP, cyc, got, exp);
      end
    endtask

    // Drivers: a frozen CPU repeats its inputs; the requester keeps its fields until ack.
    initial begin
      cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0; cpu_wr = 1'b0;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
      forever begin
        @(posedge clk);
        #1;
        if (!held_q) begin
          cpu_raddr = 16'($urandom_range(0, 15));
          cpu_wr    = ($urandom_range(0, 3) == 0);
          cpu_waddr = 16'($urandom_range(0, 15));
          cpu_wdata = 16'($urandom);
        end
        if (!ext_req || acked_q) begin
          if (phase == 0)      ext_req = 1'b0;
          else if (phase == 2) ext_req = 1'b1;
          else                 ext_req = ($urandom_range(0, 2) == 0);
          ext_we    = ($urandom_range(0, 1) == 1);
          ext_addr  = 16'($urandom_range(0, 15));
          ext_wdata = 16'($urandom);
        end
      end
    end

    // Model and monitor: grants follow from the steal-spacing rule in cycle
    // numbers; data comes from the model memory as it stood when issued.
    always @(negedge clk) begin
      logic elig, exp_free, exp_steal, exp_rv;
      logic [15:0] e;
      cyc++;
      if (mem_init) begin
        for (int a = 0; a < 256; a++) model_mem[a] = 16'h1000 + 16'(a);
      end
      elig      = ext_req & ~reset;
      exp_free  = elig & ext_we & ~cpu_wr;
      exp_steal = elig & (~ext_we | cpu_wr) & ((cyc - last_steal) > GAP);
      exp_rv    = rv_due & ~reset;

      chk("hold", 16'(cpu_hold), 16'(exp_steal));
      chk("ack", 16'(ext_ack), 16'(exp_free | exp_steal));
      chk("rvalid", 16'(ext_rvalid), 16'(exp_rv));

      if (ext_rvalid) begin
        if (ext_q.size() == 0) begin
          chk("ext_rdata_unexpected", 16'(ext_rvalid), 16'd0);
        end else begin
          e = ext_q.pop_front();
          chk("ext_rdata", ext_rdata, e);
        end
      end
      ext_q.delete();

      if (reset) begin
        cpu_q.delete();
      end else if (!exp_steal) begin
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          chk("cpu_rdata", cpu_rdata, e);
        end
        cpu_q.push_back(model_mem[cpu_raddr[7:0]]);
      end

      rv_due = exp_steal & ~ext_we;
      if (rv_due) ext_q.push_back(model_mem[ext_addr[7:0]]);

      if ((exp_free | exp_steal) && ext_we) model_mem[ext_addr[7:0]] = ext_wdata;
      if (!reset && !exp_steal && cpu_wr)   model_mem[cpu_waddr[7:0]] = cpu_wdata;

      if (exp_steal) last_steal = cyc;
      if (reset)     last_steal = -100;

      if (ext_req && !ext_ack && !reset) wait_cnt++;
      else                               wait_cnt = 0;
      if (wait_cnt > 8) begin
        chk("ext_wait_timeout", 16'(wait_cnt), 16'd0);
        wait_cnt = 0;
      end

      held_q  = cpu_hold;
      acked_q = ext_ack;
    end
  end

  // Phases: reset, CPU only, mixed random traffic, saturated external requests.
  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    phase    = 0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    repeat (40) @(posedge clk);
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      phase = 1;
      reset = ($urandom_range(0, 99) == 0);
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      phase = 2;
      reset = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
